// File: rtl/rip_common.sv
// rtl/rip_common.sv - shared types and constants for the memory arbiter
package rip_common;

  localparam int NUM_REQ = 2;

  // Requester identifier: 0 = core load/store, 1 = auxiliary/loader
  typedef logic req_id_t;

  // Transfer accepted last cycle whose response is due this cycle
  typedef struct packed {
    logic    valid;
    req_id_t owner;
    logic    is_read;
  } inflight_t;

endpackage

// File: rtl/rip_mem_arb_grant.sv
// rtl/rip_mem_arb_grant.sv - two-way grant selection, one-hot output, stateless
module rip_mem_arb_grant
  import rip_common::*;
(
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_id_t            ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  // On a tie the pointer names the winner; a lone requester always wins
  always_comb begin
    grant_o = '0;
    if (valid_i[0] && valid_i[1]) begin
      grant_o = ptr_i ? 2'b10 : 2'b01;
    end else if (valid_i[0]) begin
      grant_o = 2'b01;
    end else if (valid_i[1]) begin
      grant_o = 2'b10;
    end
  end

endmodule

// File: rtl/rip_memory_arbiter.sv
// rtl/rip_memory_arbiter.sv - shares one memory port between two requesters; RIP_MEM_ARB_RR_EN selects round-robin
module rip_memory_arbiter
  import rip_common::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic [3:0]            req_we_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [DATA_WIDTH-1:0] req_wdata_0,
  output logic                  resp_valid_0,
  output logic [DATA_WIDTH-1:0] resp_rdata_0,
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic [3:0]            req_we_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [DATA_WIDTH-1:0] req_wdata_1,
  output logic                  resp_valid_1,
  output logic [DATA_WIDTH-1:0] resp_rdata_1,
  output logic [3:0]            mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_busy
);

  logic [NUM_REQ-1:0] valid_gated;
  logic [NUM_REQ-1:0] grant;
  req_id_t            ptr;
  inflight_t          inflight_q, inflight_d;

  // Reset and a busy memory both hide every request from the grant logic
  assign valid_gated = {req_valid_1, req_valid_0} & {NUM_REQ{rstn & ~mem_busy}};

`ifdef RIP_MEM_ARB_RR_EN
  req_id_t ptr_q, ptr_d;

  // Round-robin pointer register; favours requester 0 out of reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  // The requester just granted loses the next tie; no accept leaves it alone
  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;
  end

  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  rip_mem_arb_grant u_grant (
    .valid_i (valid_gated),
    .ptr_i   (ptr),
    .grant_o (grant)
  );

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  // Forward the granted request straight to memory; idle bus is all zeros
  always_comb begin
    mem_we   = '0;
    mem_re   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (grant[0]) begin
      mem_we   = req_we_0;
      mem_re   = (req_we_0 == 4'b0000);
      mem_addr = req_addr_0;
      mem_din  = req_wdata_0;
    end else if (grant[1]) begin
      mem_we   = req_we_1;
      mem_re   = (req_we_1 == 4'b0000);
      mem_addr = req_addr_1;
      mem_din  = req_wdata_1;
    end
  end

  // Capture the accepted transfer; valid drops once its response has gone out
  always_comb begin
    inflight_d       = inflight_q;
    inflight_d.valid = 1'b0;
    if (|grant) begin
      inflight_d.valid   = 1'b1;
      inflight_d.owner   = grant[1];
      inflight_d.is_read = grant[1] ? (req_we_1 == 4'b0000) : (req_we_0 == 4'b0000);
    end
  end

  // In-flight record; reset discards any transfer still owed a response
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) inflight_q <= '0;
    else       inflight_q <= inflight_d;
  end

  // Response one cycle after accept; read data only for the owner's reads
  always_comb begin
    resp_valid_0 = rstn & inflight_q.valid & (inflight_q.owner == 1'b0);
    resp_valid_1 = rstn & inflight_q.valid & (inflight_q.owner == 1'b1);
    resp_rdata_0 = (resp_valid_0 && inflight_q.is_read) ? mem_dout : '0;
    resp_rdata_1 = (resp_valid_1 && inflight_q.is_read) ? mem_dout : '0;
  end

endmodule

// File: tb/tb_rip_memory_arbiter.sv
// tb/tb_rip_memory_arbiter.sv - self-checking bench for rip_memory_arbiter
module tb_rip_memory_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          rstn;
  logic          req_valid_0, req_valid_1;
  logic          req_ready_0, req_ready_1;
  logic [3:0]    req_we_0, req_we_1;
  logic [AW-1:0] req_addr_0, req_addr_1;
  logic [DW-1:0] req_wdata_0, req_wdata_1;
  logic          resp_valid_0, resp_valid_1;
  logic [DW-1:0] resp_rdata_0, resp_rdata_1;
  logic [3:0]    mem_we;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic          mem_busy;
  logic          preload;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  rip_memory_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .req_valid_0  (req_valid_0),
    .req_ready_0  (req_ready_0),
    .req_we_0     (req_we_0),
    .req_addr_0   (req_addr_0),
    .req_wdata_0  (req_wdata_0),
    .resp_valid_0 (resp_valid_0),
    .resp_rdata_0 (resp_rdata_0),
    .req_valid_1  (req_valid_1),
    .req_ready_1  (req_ready_1),
    .req_we_1     (req_we_1),
    .req_addr_1   (req_addr_1),
    .req_wdata_1  (req_wdata_1),
    .resp_valid_1 (resp_valid_1),
    .resp_rdata_1 (resp_rdata_1),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_dout     (mem_dout),
    .mem_busy     (mem_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h1111_0000;
      1:       return 32'h2222_0001;
      2:       return 32'h3333_0002;
      16:      return 32'hDEAD_BEEF;
      32:      return 32'hAABB_CCDD;
      default: return {8'hC0, i[7:0], 16'h5A5A};
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Synchronous single-port memory: one-cycle read latency, byte-enabled writes
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_re) mem_dout <= mem[mem_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[7:0]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end

  // Reference model: decides the winner from the arbitration rules, keeps its own
  // copy of memory and a one-deep list of the response owed next cycle
  logic        pend_v = 1'b0;
  logic        pend_o = 1'b0;
  logic [31:0] pend_d = 32'h0;
  logic        fav    = 1'b0;

  always @(negedge clk) begin
    logic        c0, c1, any, win, rd;
    logic [3:0]  we;
    logic [31:0] a, d;
    if (preload) for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    c0  = rstn && !mem_busy && req_valid_0;
    c1  = rstn && !mem_busy && req_valid_1;
    any = c0 || c1;
    win = (c0 && c1) ? fav : c1;
    we  = win ? req_we_1    : req_we_0;
    a   = win ? req_addr_1  : req_addr_0;
    d   = win ? req_wdata_1 : req_wdata_0;
    chk("ready_0",  32'(req_ready_0), 32'(any && !win));
    chk("ready_1",  32'(req_ready_1), 32'(any && win));
    chk("mem_we",   32'(mem_we),      any ? 32'(we) : 32'h0);
    chk("mem_re",   32'(mem_re),      32'(any && (we == 4'b0000)));
    chk("mem_addr", mem_addr,         any ? a : 32'h0);
    chk("mem_din",  mem_din,          any ? d : 32'h0);
    chk("resp_valid_0", 32'(resp_valid_0), 32'(rstn && pend_v && !pend_o));
    chk("resp_valid_1", 32'(resp_valid_1), 32'(rstn && pend_v && pend_o));
    chk("resp_rdata_0", resp_rdata_0, (rstn && pend_v && !pend_o) ? pend_d : 32'h0);
    chk("resp_rdata_1", resp_rdata_1, (rstn && pend_v && pend_o) ? pend_d : 32'h0);
    if (!rstn) begin
      pend_v = 1'b0;
      fav    = 1'b0;
    end else begin
      pend_v = any;
      if (any) begin
        rd     = (we == 4'b0000);
        pend_o = win;
        pend_d = rd ? ref_mem[a[7:0]] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (we[b]) ref_mem[a[7:0]][8*b +: 8] = d[8*b +: 8];
`ifdef RIP_MEM_ARB_RR_EN
        fav = !win;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid_0 = 1'b0; req_we_0 = 4'h0; req_addr_0 = '0; req_wdata_0 = '0;
    req_valid_1 = 1'b0; req_we_1 = 4'h0; req_addr_1 = '0; req_wdata_1 = '0;
    mem_busy    = 1'b0;
  endtask

  task automatic req0(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    req_valid_0 = 1'b1; req_we_0 = we; req_addr_0 = a; req_wdata_0 = d;
  endtask

  task automatic req1(input logic [3:0] we, input logic [31:0] a, input logic [31:0] d);
    req_valid_1 = 1'b1; req_we_1 = we; req_addr_1 = a; req_wdata_1 = d;
  endtask

  typedef struct {
    logic v0; logic [3:0] we0; logic [31:0] a0; logic [31:0] d0;
    logic v1; logic [3:0] we1; logic [31:0] a1; logic [31:0] d1;
    logic busy;
  } vec_t;

  vec_t       tbl [6];
  logic [1:0] exp29 [4];
  logic [1:0] exp31;

  initial begin
    tbl[0] = '{1'b1, 4'hF, 32'h30, 32'hCAFE_F00D, 1'b1, 4'h0, 32'h30, 32'h0,         1'b0};
    tbl[1] = '{1'b1, 4'h0, 32'h30, 32'h0,         1'b1, 4'hC, 32'h30, 32'h9988_0000, 1'b0};
    tbl[2] = '{1'b0, 4'h0, 32'h0,  32'h0,         1'b1, 4'h0, 32'h30, 32'h0,         1'b0};
    tbl[3] = '{1'b1, 4'h0, 32'h31, 32'h0,         1'b1, 4'h0, 32'h32, 32'h0,         1'b1};
    tbl[4] = '{1'b1, 4'h4, 32'h31, 32'h0077_0000, 1'b1, 4'h0, 32'h30, 32'h0,         1'b0};
    tbl[5] = '{1'b0, 4'h0, 32'h0,  32'h0,         1'b0, 4'h0, 32'h0,  32'h0,         1'b0};
`ifdef RIP_MEM_ARB_RR_EN
    exp29[0] = 2'b01; exp29[1] = 2'b10; exp29[2] = 2'b01; exp29[3] = 2'b10;
    exp31    = 2'b10;
`else
    exp29[0] = 2'b01; exp29[1] = 2'b01; exp29[2] = 2'b01; exp29[3] = 2'b01;
    exp31    = 2'b01;
`endif

    // Reset state with requests already presented
    rstn = 1'b0; preload = 1'b1; idle();
    req0(4'h0, 32'h10, 32'h0);
    req1(4'h3, 32'h11, 32'h5555_5555);
    @(negedge clk);
    chk("rst_ready_0", 32'(req_ready_0), 32'h0);
    chk("rst_ready_1", 32'(req_ready_1), 32'h0);
    chk("rst_mem_re",  32'(mem_re),      32'h0);
    chk("rst_mem_we",  32'(mem_we),      32'h0);
    chk("rst_mem_addr", mem_addr,        32'h0);
    tick(); preload = 1'b0; idle();
    tick(); rstn = 1'b1;

    // Single read by requester 0
    tick(); req0(4'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("t28_ready_0", 32'(req_ready_0), 32'h1);
    chk("t28_mem_re",  32'(mem_re),      32'h1);
    chk("t28_addr",    mem_addr,         32'h10);
    tick(); idle();
    @(negedge clk);
    chk("t28_resp_valid_0", 32'(resp_valid_0), 32'h1);
    chk("t28_rdata_0",      resp_rdata_0,      32'hDEAD_BEEF);
    chk("t28_resp_valid_1", 32'(resp_valid_1), 32'h0);

    // Contention from a fresh pointer
    tick(); rstn = 1'b0;
    @(negedge clk);
    tick(); rstn = 1'b1;
    req0(4'h0, 32'h3, 32'h0);
    req1(4'h0, 32'h4, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("t29_grant%0d", k), 32'({req_ready_1, req_ready_0}), 32'(exp29[k]));
      tick();
    end
    idle();

    // Partial write by requester 1 then read-back by requester 0
    req1(4'b0011, 32'h20, 32'h1234_5678);
    @(negedge clk);
    chk("t30_ready_1", 32'(req_ready_1), 32'h1);
    chk("t30_mem_we",  32'(mem_we),      32'h3);
    tick(); idle(); req0(4'h0, 32'h20, 32'h0);
    @(negedge clk);
    chk("t30_ready_0",      32'(req_ready_0),  32'h1);
    chk("t30_resp_valid_1", 32'(resp_valid_1), 32'h1);
    chk("t30_rdata_1",      resp_rdata_1,      32'h0);
    tick(); idle();
    @(negedge clk);
    chk("t30_resp_valid_0", 32'(resp_valid_0), 32'h1);
    chk("t30_rdata_0",      resp_rdata_0,      32'hAABB_5678);

    // Memory busy stalls everyone
    tick(); idle();
    req0(4'h0, 32'h5, 32'h0);
    req1(4'h0, 32'h6, 32'h0);
    mem_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t31_busy_ready", 32'({req_ready_1, req_ready_0}), 32'h0);
      chk("t31_busy_we",    32'(mem_we), 32'h0);
      chk("t31_busy_re",    32'(mem_re), 32'h0);
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("t31_first_grant", 32'({req_ready_1, req_ready_0}), 32'(exp31));
    tick(); idle();

    // Mixed vectors checked by the model alone
    for (int k = 0; k < 6; k++) begin
      idle();
      if (tbl[k].v0) req0(tbl[k].we0, tbl[k].a0, tbl[k].d0);
      if (tbl[k].v1) req1(tbl[k].we1, tbl[k].a1, tbl[k].d1);
      mem_busy = tbl[k].busy;
      tick();
    end
    idle();

    // Back-to-back reads
    req0(4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t32_ready_c0", 32'(req_ready_0), 32'h1);
    tick(); req0(4'h0, 32'h1, 32'h0);
    @(negedge clk);
    chk("t32_ready_c1", 32'(req_ready_0),  32'h1);
    chk("t32_resp_c1",  32'(resp_valid_0), 32'h1);
    chk("t32_data_c1",  resp_rdata_0,      32'h1111_0000);
    tick(); req0(4'h0, 32'h2, 32'h0);
    @(negedge clk);
    chk("t32_ready_c2", 32'(req_ready_0),  32'h1);
    chk("t32_resp_c2",  32'(resp_valid_0), 32'h1);
    chk("t32_data_c2",  resp_rdata_0,      32'h2222_0001);
    tick(); idle();
    @(negedge clk);
    chk("t32_resp_c3",  32'(resp_valid_0), 32'h1);
    chk("t32_data_c3",  resp_rdata_0,      32'h3333_0002);
    tick();
    @(negedge clk);
    chk("t32_resp_c4",  32'(resp_valid_0), 32'h0);

    // Reset right after an accept drops the owed response
    tick(); req0(4'h0, 32'h10, 32'h0);
    @(negedge clk);
    chk("t33_ready_0", 32'(req_ready_0), 32'h1);
    for (int k = 0; k < 2; k++) begin
      tick(); rstn = 1'b0;
      @(negedge clk);
      chk("t33_rst_resp_valid_0", 32'(resp_valid_0), 32'h0);
      chk("t33_rst_rdata_0",      resp_rdata_0,      32'h0);
      chk("t33_rst_ready_0",      32'(req_ready_0),  32'h0);
      chk("t33_rst_mem_re",       32'(mem_re),       32'h0);
      chk("t33_rst_mem_addr",     mem_addr,          32'h0);
    end
    tick(); rstn = 1'b1; idle();
    @(negedge clk);
    chk("t33_post_resp_valid_0", 32'(resp_valid_0), 32'h0);
    chk("t33_post_resp_valid_1", 32'(resp_valid_1), 32'h0);
    chk("t33_post_mem_re",       32'(mem_re),       32'h0);
    chk("t33_post_mem_addr",     mem_addr,          32'h0);
    tick();
    @(negedge clk);
    chk("t33_post2_resp_valid_0", 32'(resp_valid_0), 32'h0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
